// File: rtl/branch_redirect_ctrl.sv
// Execute-stage branch resolution: detects mispredicts, issues one registered redirect to fetch,
// and holds flush/stall across the redirect and a drain window. Optional counters: BRANCH_PERF_CNT_EN.
module branch_redirect_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jump_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            redirect_ready_i,
  output logic            flush_o,
  output logic            stall_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  localparam int DW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_t          state, state_nxt;
  logic [DW-1:0]   drain;
  logic [XLEN-1:0] redirect_pc;
  logic            resolve, accept, act_taken, mispredict, hshake;
  logic [XLEN-1:0] act_pc;

  // A jump is always taken, so "both type bits set" naturally behaves as a jump.
  assign resolve    = ex_valid_i & (ex_is_branch_i | ex_is_jump_i);
  assign accept     = (state == IDLE) & resolve;
  assign act_taken  = ex_is_jump_i | br_taken_i;
  assign act_pc     = act_taken ? br_target_i : ex_pc_i + XLEN'(4);
  assign mispredict = (act_taken != pred_taken_i) |
                      (act_taken & pred_taken_i & (pred_target_i != br_target_i));
  assign hshake     = (state == REDIRECT) & redirect_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && mispredict) state_nxt = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_nxt = (FLUSH_CYCLES == 0) ? IDLE : DRAIN;
      DRAIN:    if (drain <= DW'(1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    redirect_valid_o = (state == REDIRECT);
    stall_o          = (state == REDIRECT);
    flush_o          = (state != IDLE);
    redirect_pc_o    = redirect_pc;
  end

  // Redirect PC is captured only on an accepted mispredict, so it stays stable while pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_pc <= '0;
      drain       <= '0;
    end else begin
      if (accept && mispredict) redirect_pc <= act_pc;
      if (hshake)               drain <= DW'(FLUSH_CYCLES);
      else if (state == DRAIN)  drain <= drain - DW'(1);
    end
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (accept) begin
      branch_cnt <= branch_cnt + CNT_W'(1);
      if (mispredict) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
    end
  end

  assign branch_cnt_o     = branch_cnt;
  assign mispredict_cnt_o = mispredict_cnt;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: default drain window plus a FLUSH_CYCLES=0 instance.
module tb_branch_redirect_ctrl;
  logic        clk = 0;
  logic        rst = 1;
  logic        ex_valid = 0, ex_is_branch = 0, ex_is_jump = 0;
  logic [31:0] ex_pc = '0, pred_target = '0, br_target = '0;
  logic        pred_taken = 0, br_taken = 0, ready = 0;

  logic        rv, fl, st, rv0, fl0, st0;
  logic [31:0] rpc, rpc0, bcnt, mcnt, bcnt0, mcnt0;

  int errors = 0;
  int checks = 0;
  int exp_b  = 0;
  int exp_m  = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_is_branch_i(ex_is_branch),
    .ex_is_jump_i(ex_is_jump), .ex_pc_i(ex_pc), .pred_taken_i(pred_taken),
    .pred_target_i(pred_target), .br_taken_i(br_taken), .br_target_i(br_target),
    .redirect_valid_o(rv), .redirect_pc_o(rpc), .redirect_ready_i(ready),
    .flush_o(fl), .stall_o(st), .branch_cnt_o(bcnt), .mispredict_cnt_o(mcnt));

  branch_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(0), .CNT_W(32)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .ex_valid_i(ex_valid), .ex_is_branch_i(ex_is_branch),
    .ex_is_jump_i(ex_is_jump), .ex_pc_i(ex_pc), .pred_taken_i(pred_taken),
    .pred_target_i(pred_target), .br_taken_i(br_taken), .br_target_i(br_target),
    .redirect_valid_o(rv0), .redirect_pc_o(rpc0), .redirect_ready_i(ready),
    .flush_o(fl0), .stall_o(st0), .branch_cnt_o(bcnt0), .mispredict_cnt_o(mcnt0));

  // Counters only exist with the macro; otherwise they must read 0.
  function automatic logic [31:0] cx(input int v);
`ifdef BRANCH_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v) & 32'h0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one resolve for a single cycle, then drop ex_valid.
  task automatic do_resolve(input logic b, input logic j, input logic [31:0] pc, input logic pt,
                            input logic [31:0] ptg, input logic bt, input logic [31:0] btg);
    ex_is_branch = b; ex_is_jump = j; ex_pc = pc; pred_taken = pt; pred_target = ptg;
    br_taken = bt; br_target = btg; ex_valid = 1;
    tick();
    ex_valid = 0;
  endtask

  task automatic idle_wait();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1;
    #12;
    checks++;
    if ({rv, fl, st} !== 3'b000) begin errors++; $display("FAIL reset_ctl: got %b expected 000", {rv, fl, st}); end
    checks++;
    if (rpc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", rpc); end
    checks++;
    if ({bcnt, mcnt} !== 64'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h expected 0/0", bcnt, mcnt); end
    checks++;
    if ({rv0, fl0, st0} !== 3'b000) begin errors++; $display("FAIL reset_ctl0: got %b expected 000", {rv0, fl0, st0}); end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_correct_pred();
    ready = 0;
    do_resolve(1, 0, 32'h1000, 1, 32'h1010, 1, 32'h1010);
    exp_b++;
    checks++;
    if ({rv, fl, st} !== 3'b000) begin errors++; $display("FAIL correct_ctl: got %b expected 000", {rv, fl, st}); end
    checks++;
    if (bcnt !== cx(exp_b) || mcnt !== cx(exp_m)) begin
      errors++; $display("FAIL correct_cnt: got %0d/%0d expected %0d/%0d", bcnt, mcnt, cx(exp_b), cx(exp_m));
    end
    tick();
    checks++;
    if (rv !== 1'b0) begin errors++; $display("FAIL correct_hold: got %b expected 0", rv); end
  endtask

  task automatic test_backpressure();
    ready = 0;
    do_resolve(1, 0, 32'h1000, 0, 32'h0, 1, 32'h1010);
    exp_b++; exp_m++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rv, fl, st} !== 3'b111 || rpc !== 32'h1010) begin
        errors++; $display("FAIL bp_hold%0d: got %b pc %h expected 111 pc 00001010", i, {rv, fl, st}, rpc);
      end
      checks++;
      if (bcnt !== cx(exp_b) || mcnt !== cx(exp_m)) begin
        errors++; $display("FAIL bp_cnt%0d: got %0d/%0d expected %0d/%0d", i, bcnt, mcnt, cx(exp_b), cx(exp_m));
      end
      // Wrong-path mispredict while the redirect is pending must be dropped.
      if (i == 0) do_resolve(1, 0, 32'h2000, 0, 32'h0, 1, 32'h3000);
      else if (i == 1) tick();
    end
    ready = 1;
    tick();
    ready = 0;
    checks++;
    if ({rv, fl, st} !== 3'b010) begin errors++; $display("FAIL bp_drain1: got %b expected 010", {rv, fl, st}); end
    checks++;
    if ({rv0, fl0, st0} !== 3'b000) begin errors++; $display("FAIL bp_flush0: got %b expected 000", {rv0, fl0, st0}); end
    tick();
    checks++;
    if ({rv, fl, st} !== 3'b010) begin errors++; $display("FAIL bp_drain2: got %b expected 010", {rv, fl, st}); end
    tick();
    checks++;
    if ({rv, fl, st} !== 3'b000) begin errors++; $display("FAIL bp_idle: got %b expected 000", {rv, fl, st}); end
    idle_wait();
  endtask

  task automatic test_taken_not_taken();
    ready = 1;
    do_resolve(1, 0, 32'h1000, 1, 32'h1010, 0, 32'h1010);
    exp_b++; exp_m++;
    checks++;
    if (rv !== 1'b1 || rpc !== 32'h1004) begin errors++; $display("FAIL tnt_pc: got %b %h expected 1 00001004", rv, rpc); end
    checks++;
    if (mcnt !== cx(exp_m)) begin errors++; $display("FAIL tnt_cnt: got %0d expected %0d", mcnt, cx(exp_m)); end
    tick();
    checks++;
    if ({rv, fl, st} !== 3'b010) begin errors++; $display("FAIL tnt_1cyc: got %b expected 010", {rv, fl, st}); end
    idle_wait();
  endtask

  task automatic test_jump();
    ready = 1;
    do_resolve(0, 1, 32'h1000, 1, 32'h2000, 0, 32'h1010);
    exp_b++; exp_m++;
    checks++;
    if (rv !== 1'b1 || rpc !== 32'h1010) begin errors++; $display("FAIL jmp_wrong: got %b %h expected 1 00001010", rv, rpc); end
    idle_wait();
    do_resolve(0, 1, 32'h1000, 1, 32'h1010, 0, 32'h1010);
    exp_b++;
    checks++;
    if ({rv, fl, st} !== 3'b000) begin errors++; $display("FAIL jmp_right: got %b expected 000", {rv, fl, st}); end
    // Both type bits set: treated as a taken jump, so a not-taken prediction misses.
    do_resolve(1, 1, 32'h1100, 0, 32'h0, 0, 32'h1200);
    exp_b++; exp_m++;
    checks++;
    if (rv !== 1'b1 || rpc !== 32'h1200) begin errors++; $display("FAIL jmp_both: got %b %h expected 1 00001200", rv, rpc); end
    checks++;
    if (bcnt !== cx(exp_b) || mcnt !== cx(exp_m)) begin
      errors++; $display("FAIL jmp_cnt: got %0d/%0d expected %0d/%0d", bcnt, mcnt, cx(exp_b), cx(exp_m));
    end
    idle_wait();
  endtask

  task automatic test_edges();
    ready = 1;
    // Mispredicting fields but ex_valid low: no resolve event.
    ex_is_branch = 1; ex_pc = 32'h1000; pred_taken = 0; br_taken = 1; br_target = 32'h4000; ex_valid = 0;
    tick();
    checks++;
    if ({rv, fl, st} !== 3'b000 || bcnt !== cx(exp_b)) begin
      errors++; $display("FAIL novalid: got %b cnt %0d expected 000 cnt %0d", {rv, fl, st}, bcnt, cx(exp_b));
    end
    do_resolve(1, 0, 32'hFFFF_FFFC, 1, 32'h10, 0, 32'h10);
    exp_b++; exp_m++;
    checks++;
    if (rv !== 1'b1 || rpc !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %b %h expected 1 00000000", rv, rpc); end
    checks++;
    if (rv0 !== 1'b1 || rpc0 !== 32'h0) begin errors++; $display("FAIL wrap_pc0: got %b %h expected 1 00000000", rv0, rpc0); end
    tick();
    checks++;
    if ({rv0, fl0, st0} !== 3'b000) begin errors++; $display("FAIL flush0_drop: got %b expected 000", {rv0, fl0, st0}); end
    idle_wait();
  endtask

  task automatic test_reset_mid();
    ready = 0;
    do_resolve(1, 0, 32'h1000, 0, 32'h0, 1, 32'h1010);
    checks++;
    if (rv !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b expected 1", rv); end
    #2 rst = 1;
    #1;
    exp_b = 0; exp_m = 0;
    checks++;
    if ({rv, fl, st} !== 3'b000 || rpc !== 32'h0 || {bcnt, mcnt} !== 64'h0) begin
      errors++; $display("FAIL rstmid_async: got %b pc %h cnt %0d/%0d expected 000 pc 0 cnt 0/0", {rv, fl, st}, rpc, bcnt, mcnt);
    end
    #1 rst = 0;
    tick();
    checks++;
    if ({rv, fl, st} !== 3'b000) begin errors++; $display("FAIL rstmid_idle: got %b expected 000", {rv, fl, st}); end
    do_resolve(1, 0, 32'h2000, 0, 32'h0, 1, 32'h2040);
    exp_b++; exp_m++;
    checks++;
    if (rv !== 1'b1 || rpc !== 32'h2040) begin errors++; $display("FAIL rstmid_resume: got %b %h expected 1 00002040", rv, rpc); end
    checks++;
    if (bcnt !== cx(exp_b) || mcnt !== cx(exp_m)) begin
      errors++; $display("FAIL rstmid_cnt: got %0d/%0d expected %0d/%0d", bcnt, mcnt, cx(exp_b), cx(exp_m));
    end
  endtask

  initial begin
    test_reset();
    test_correct_pred();
    test_backpressure();
    test_taken_not_taken();
    test_jump();
    test_edges();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
